// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for mem_ctrl: FSM states, request record, byte-lane helper.
package mem_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;

    // mem_a[17:16] value that selects the UART window
    localparam logic [1:0] IO_WINDOW = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [2:0]        size;
        logic              wr;
    } req_t;

    function automatic logic [BYTE_W-1:0] byte_lane(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] idx);
        return word[{idx, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller: fetch and load/store clients, LSB priority, drop/rollback aborts.
// Optional IO_STALL_EN macro: stores into the UART window wait while io_buffer_full is high.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] pc_from_if,
    input  logic              ena_from_if,
    input  logic              drop_flag_from_if,
    output logic              ok_flag_to_if,
    output logic [DATA_W-1:0] inst_to_if,
    input  logic [ADDR_W-1:0] addr_from_lsb,
    input  logic              ena_from_lsb,
    input  logic              wr_flag_from_lsb,
    input  logic [2:0]        size_from_lsb,
    input  logic [DATA_W-1:0] data_from_lsb,
    output logic              ok_flag_to_lsb,
    output logic [DATA_W-1:0] data_to_lsb,
    input  logic              rollback_flag_from_rob,
    input  logic [BYTE_W-1:0] mem_din,
    output logic [BYTE_W-1:0] mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_t            state;
    req_t              pend_ls_req, cur, ls_in, ls_sel;
    logic              pend_ls, pend_if, cur_fetch, wr_q;
    logic [ADDR_W-1:0] pend_if_pc, if_addr, next_addr;
    logic [2:0]        cnt, next_cnt;
    logic [1:0]        lane;
    logic [DATA_W-1:0] word, word_next;
    logic              ls_new, ls_live, if_live, take_ls, take_if, abort, stall;
    logic              held;
    logic [BYTE_W-1:0] din_hold, din;

`ifdef IO_STALL_EN
    assign stall = (state == WRITE) && io_buffer_full && (mem_a[17:16] == IO_WINDOW);
`else
    logic unused_io;
    assign unused_io = io_buffer_full;
    assign stall     = 1'b0;
`endif

    assign mem_wr = wr_q && rdy && !stall;

    always_comb begin
        ls_in     = '{addr: addr_from_lsb, data: data_from_lsb,
                      size: size_from_lsb, wr: wr_flag_from_lsb};
        ls_new    = ena_from_lsb && !(rollback_flag_from_rob && !wr_flag_from_lsb);
        ls_live   = pend_ls && !(rollback_flag_from_rob && !pend_ls_req.wr);
        if_live   = (pend_if || ena_from_if) && !drop_flag_from_if;
        ls_sel    = ls_live ? pend_ls_req : ls_in;
        if_addr   = pend_if ? pend_if_pc : pc_from_if;
        take_ls   = (state == IDLE) && (ls_live || ls_new);
        take_if   = (state == IDLE) && !take_ls && if_live;
        abort     = (state == READ) &&
                    (cur_fetch ? drop_flag_from_if : (rollback_flag_from_rob && !cur.wr));
        // After a rdy-low gap mem_din reflects the held mem_a, not the byte still owed
        din       = held ? din_hold : mem_din;
        lane      = cnt[1:0] - 2'd1;
        word_next = word;
        if (cnt != 3'd0)
            word_next[{lane, 3'b000} +: BYTE_W] = din;
        next_cnt  = cnt + 3'd1;
        next_addr = cur.addr + {29'd0, cnt} + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            pend_ls        <= 1'b0;
            pend_if        <= 1'b0;
            pend_ls_req    <= '0;
            pend_if_pc     <= '0;
            cur            <= '0;
            cur_fetch      <= 1'b0;
            cnt            <= 3'd0;
            word           <= '0;
            wr_q           <= 1'b0;
            mem_a          <= '0;
            mem_dout       <= '0;
            ok_flag_to_if  <= 1'b0;
            ok_flag_to_lsb <= 1'b0;
            inst_to_if     <= '0;
            data_to_lsb    <= '0;
            held           <= 1'b0;
            din_hold       <= '0;
        end else if (!rdy) begin
            if (!held) begin
                held     <= 1'b1;
                din_hold <= mem_din;
            end
        end else begin
            held           <= 1'b0;
            ok_flag_to_if  <= 1'b0;
            ok_flag_to_lsb <= 1'b0;

            if (take_ls)
                pend_ls <= 1'b0;
            else if (ls_new) begin
                pend_ls     <= 1'b1;
                pend_ls_req <= ls_in;
            end else if (rollback_flag_from_rob && !pend_ls_req.wr)
                pend_ls <= 1'b0;

            if (take_if || drop_flag_from_if)
                pend_if <= 1'b0;
            else if (ena_from_if) begin
                pend_if    <= 1'b1;
                pend_if_pc <= pc_from_if;
            end

            case (state)
                IDLE: begin
                    cnt  <= 3'd0;
                    word <= '0;
                    if (take_ls) begin
                        cur       <= ls_sel;
                        cur_fetch <= 1'b0;
                        state     <= ls_sel.wr ? WRITE : READ;
                        mem_a     <= ls_sel.addr;
                        wr_q      <= ls_sel.wr;
                        mem_dout  <= byte_lane(ls_sel.data, 2'd0);
                    end else if (take_if) begin
                        cur       <= '{addr: if_addr, data: '0, size: 3'd4, wr: 1'b0};
                        cur_fetch <= 1'b1;
                        state     <= READ;
                        mem_a     <= if_addr;
                        wr_q      <= 1'b0;
                    end
                end
                READ: begin
                    if (abort)
                        state <= IDLE;
                    else begin
                        word <= word_next;
                        if (cnt == cur.size) begin
                            state <= IDLE;
                            if (cur_fetch) begin
                                inst_to_if    <= word_next;
                                ok_flag_to_if <= 1'b1;
                            end else begin
                                data_to_lsb    <= word_next;
                                ok_flag_to_lsb <= 1'b1;
                            end
                        end else begin
                            cnt <= next_cnt;
                            if (next_cnt != cur.size)
                                mem_a <= next_addr;
                        end
                    end
                end
                WRITE: begin
                    if (!stall) begin
                        if (next_cnt == cur.size) begin
                            wr_q           <= 1'b0;
                            ok_flag_to_lsb <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            cnt      <= next_cnt;
                            mem_a    <= next_addr;
                            mem_dout <= byte_lane(cur.data, next_cnt[1:0]);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: expected ok/write events queued at stimulus, matched to observed events.
module tb_mem_ctrl;

    logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1;
    logic [31:0] pc_from_if = '0, addr_from_lsb = '0, data_from_lsb = '0;
    logic        ena_from_if = 1'b0, drop_flag_from_if = 1'b0;
    logic        ena_from_lsb = 1'b0, wr_flag_from_lsb = 1'b0, rollback_flag_from_rob = 1'b0;
    logic [2:0]  size_from_lsb = '0;
    logic [7:0]  mem_din = '0;
    logic        io_buffer_full = 1'b0;
    logic        ok_flag_to_if, ok_flag_to_lsb, mem_wr;
    logic [31:0] inst_to_if, data_to_lsb, mem_a;
    logic [7:0]  mem_dout;

    int          total = 0, bad = 0;
    int unsigned cyc = 0;
    logic [7:0]  ram [0:262143];

    typedef struct packed { int unsigned t; logic [31:0] val; } ev_t;
    typedef struct packed { int unsigned t; logic [31:0] addr; logic [7:0] b; } wev_t;
    ev_t  obs_if[$], obs_ls[$], exp_if[$], exp_ls[$];
    wev_t obs_wr[$], exp_wr[$];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .pc_from_if(pc_from_if), .ena_from_if(ena_from_if),
        .drop_flag_from_if(drop_flag_from_if),
        .ok_flag_to_if(ok_flag_to_if), .inst_to_if(inst_to_if),
        .addr_from_lsb(addr_from_lsb), .ena_from_lsb(ena_from_lsb),
        .wr_flag_from_lsb(wr_flag_from_lsb), .size_from_lsb(size_from_lsb),
        .data_from_lsb(data_from_lsb), .ok_flag_to_lsb(ok_flag_to_lsb),
        .data_to_lsb(data_to_lsb), .rollback_flag_from_rob(rollback_flag_from_rob),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        mem_din <= ram[mem_a[17:0]];
    end

    always @(negedge clk) begin
        if (ok_flag_to_if)  obs_if.push_back('{cyc, inst_to_if});
        if (ok_flag_to_lsb) obs_ls.push_back('{cyc, data_to_lsb});
        if (mem_wr)         obs_wr.push_back('{cyc, mem_a, mem_dout});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_if.delete(); obs_ls.delete(); obs_wr.delete();
        exp_if.delete(); exp_ls.delete(); exp_wr.delete();
    endtask

    task automatic drive_ls(input logic [31:0] a, input logic w, input logic [2:0] s,
                            input logic [31:0] d);
        addr_from_lsb = a; wr_flag_from_lsb = w; size_from_lsb = s;
        data_from_lsb = d; ena_from_lsb = 1'b1;
    endtask

    task automatic release_pulses();
        ena_from_if = 1'b0; ena_from_lsb = 1'b0;
        drop_flag_from_if = 1'b0; rollback_flag_from_rob = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total += 7;
        if (ok_flag_to_if !== 1'b0)  begin bad++; $display("FAIL reset_ok_if got=%b want=0", ok_flag_to_if); end
        if (ok_flag_to_lsb !== 1'b0) begin bad++; $display("FAIL reset_ok_lsb got=%b want=0", ok_flag_to_lsb); end
        if (mem_wr !== 1'b0)         begin bad++; $display("FAIL reset_mem_wr got=%b want=0", mem_wr); end
        if (mem_a !== 32'h0)         begin bad++; $display("FAIL reset_mem_a got=%h want=0", mem_a); end
        if (mem_dout !== 8'h0)       begin bad++; $display("FAIL reset_mem_dout got=%h want=0", mem_dout); end
        if (inst_to_if !== 32'h0)    begin bad++; $display("FAIL reset_inst got=%h want=0", inst_to_if); end
        if (data_to_lsb !== 32'h0)   begin bad++; $display("FAIL reset_data got=%h want=0", data_to_lsb); end
        tick(2);
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_fetch();
        int unsigned t;
        ev_t e, o;
        clear_obs();
        pc_from_if = 32'h100; ena_from_if = 1'b1; t = cyc;
        exp_if.push_back('{t + 6, 32'h0000_0513});
        for (int i = 0; i < 4; i++) begin
            tick(1);
            release_pulses();
            total++;
            if (mem_a !== 32'h100 + i) begin
                bad++; $display("FAIL fetch_addr%0d got=%h want=%h", i, mem_a, 32'h100 + i);
            end
        end
        tick(5);
        total++;
        if (obs_if.size() != exp_if.size()) begin
            bad++; $display("FAIL fetch_count got=%0d want=%0d", obs_if.size(), exp_if.size());
        end
        while (exp_if.size() > 0 && obs_if.size() > 0) begin
            e = exp_if.pop_front(); o = obs_if.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL fetch_ok got=%0d/%h want=%0d/%h", o.t, o.val, e.t, e.val); end
        end
    endtask

    task automatic test_concurrent();
        int unsigned t;
        ev_t e, o;
        clear_obs();
        pc_from_if = 32'h100; ena_from_if = 1'b1;
        drive_ls(32'h2001, 1'b0, 3'd2, 32'h0);
        t = cyc;
        exp_ls.push_back('{t + 4, 32'h0000_BBAA});
        exp_if.push_back('{t + 10, 32'h0000_0513});
        tick(1); release_pulses(); tick(13);
        total++;
        if (obs_ls.size() != 1 || obs_if.size() != 1) begin
            bad++; $display("FAIL conc_count got=%0d,%0d want=1,1", obs_ls.size(), obs_if.size());
        end
        while (exp_ls.size() > 0 && obs_ls.size() > 0) begin
            e = exp_ls.pop_front(); o = obs_ls.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL conc_lsb got=%0d/%h want=%0d/%h", o.t, o.val, e.t, e.val); end
        end
        while (exp_if.size() > 0 && obs_if.size() > 0) begin
            e = exp_if.pop_front(); o = obs_if.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL conc_if got=%0d/%h want=%0d/%h", o.t, o.val, e.t, e.val); end
        end
    endtask

    // Store scenario: optional rollback or rdy-low cycle at a given offset from the pulse
    task automatic test_store(input string name, input logic [31:0] a, input logic [2:0] s,
                              input logic [31:0] d, input int rb_at, input int rdy_at);
        int unsigned t, gap;
        wev_t ew, ow;
        ev_t  o;
        clear_obs();
        drive_ls(a, 1'b1, s, d);
        t = cyc;
        gap = 0;
        for (int i = 0; i < int'(s); i++) begin
            if (rdy_at >= 1 && i + 1 >= rdy_at) gap = 1;
            exp_wr.push_back('{t + 1 + i + gap, a + i, d[8*i +: 8]});
        end
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            release_pulses();
            rdy = 1'b1;
            if (k == rb_at)  rollback_flag_from_rob = 1'b1;
            if (k == rdy_at) rdy = 1'b0;
        end
        release_pulses();
        rdy = 1'b1;
        tick(2);
        total++;
        if (obs_wr.size() != exp_wr.size()) begin
            bad++; $display("FAIL %s_wcount got=%0d want=%0d", name, obs_wr.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            ew = exp_wr.pop_front(); ow = obs_wr.pop_front(); total++;
            if (ow !== ew) begin
                bad++; $display("FAIL %s_write got=%0d/%h/%h want=%0d/%h/%h", name,
                                ow.t, ow.addr, ow.b, ew.t, ew.addr, ew.b);
            end
        end
        total++;
        if (obs_ls.size() != 1) begin
            bad++; $display("FAIL %s_okcount got=%0d want=1", name, obs_ls.size());
        end else begin
            o = obs_ls.pop_front(); total++;
            if (o.t !== t + int'(s) + 1 + gap) begin
                bad++; $display("FAIL %s_ok_cycle got=%0d want=%0d", name, o.t, t + int'(s) + 1 + gap);
            end
        end
    endtask

    task automatic test_drop();
        int unsigned t;
        ev_t e, o;
        clear_obs();
        pc_from_if = 32'h100; ena_from_if = 1'b1;
        tick(1); release_pulses(); tick(1);
        drop_flag_from_if = 1'b1;
        tick(1); release_pulses(); tick(8);
        total++;
        if (obs_if.size() != 0) begin bad++; $display("FAIL drop_inflight got=%0d oks want=0", obs_if.size()); end
        pc_from_if = 32'h100; ena_from_if = 1'b1; drop_flag_from_if = 1'b1;
        tick(1); release_pulses(); tick(8);
        total++;
        if (obs_if.size() != 0) begin bad++; $display("FAIL drop_wins got=%0d oks want=0", obs_if.size()); end
        pc_from_if = 32'h200; ena_from_if = 1'b1; t = cyc;
        exp_if.push_back('{t + 6, 32'h0001_0137});
        tick(1); release_pulses(); tick(8);
        total++;
        if (obs_if.size() != 1) begin bad++; $display("FAIL drop_refetch_count got=%0d want=1", obs_if.size()); end
        while (exp_if.size() > 0 && obs_if.size() > 0) begin
            e = exp_if.pop_front(); o = obs_if.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL drop_refetch got=%0d/%h want=%0d/%h", o.t, o.val, e.t, e.val); end
        end
    endtask

    task automatic test_rollback_load();
        int unsigned t;
        ev_t e, o;
        clear_obs();
        drive_ls(32'h2001, 1'b0, 3'd4, 32'h0);
        t = cyc;
        tick(1); release_pulses(); tick(1);
        rollback_flag_from_rob = 1'b1;
        tick(1); release_pulses();
        drive_ls(32'h2002, 1'b0, 3'd1, 32'h0);
        exp_ls.push_back('{t + 6, 32'h0000_00BB});
        tick(1); release_pulses(); tick(8);
        pc_from_if = 32'h100; ena_from_if = 1'b1; t = cyc;
        exp_if.push_back('{t + 6, 32'h0000_0513});
        tick(1); release_pulses();
        drive_ls(32'h2001, 1'b0, 3'd1, 32'h0);
        tick(1); release_pulses();
        rollback_flag_from_rob = 1'b1;
        tick(1); release_pulses(); tick(10);
        total++;
        if (obs_ls.size() != exp_ls.size()) begin
            bad++; $display("FAIL rb_load_count got=%0d want=%0d", obs_ls.size(), exp_ls.size());
        end
        while (exp_ls.size() > 0 && obs_ls.size() > 0) begin
            e = exp_ls.pop_front(); o = obs_ls.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL rb_load_next got=%0d/%h want=%0d/%h", o.t, o.val, e.t, e.val); end
        end
        while (exp_if.size() > 0 && obs_if.size() > 0) begin
            e = exp_if.pop_front(); o = obs_if.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL rb_fetch got=%0d/%h want=%0d/%h", o.t, o.val, e.t, e.val); end
        end
    endtask

    task automatic test_rdy_fetch();
        int unsigned t;
        ev_t e, o;
        clear_obs();
        pc_from_if = 32'h100; ena_from_if = 1'b1; t = cyc;
        exp_if.push_back('{t + 8, 32'h0000_0513});
        tick(1); release_pulses(); tick(1);
        rdy = 1'b0;
        tick(2);
        rdy = 1'b1;
        tick(8);
        total++;
        if (obs_if.size() != 1) begin bad++; $display("FAIL rdy_fetch_count got=%0d want=1", obs_if.size()); end
        while (exp_if.size() > 0 && obs_if.size() > 0) begin
            e = exp_if.pop_front(); o = obs_if.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL rdy_fetch got=%0d/%h want=%0d/%h", o.t, o.val, e.t, e.val); end
        end
    endtask

`ifdef IO_STALL_EN
    task automatic test_io_stall();
        int unsigned t;
        wev_t ow;
        clear_obs();
        drive_ls(32'h0003_0000, 1'b1, 3'd1, 32'h41);
        t = cyc;
        tick(1); release_pulses();
        io_buffer_full = 1'b1;
        tick(3);
        io_buffer_full = 1'b0;
        tick(6);
        total++;
        if (obs_wr.size() != 1) begin
            bad++; $display("FAIL io_wcount got=%0d want=1", obs_wr.size());
        end else begin
            ow = obs_wr.pop_front(); total++;
            if (ow !== '{t + 4, 32'h0003_0000, 8'h41}) begin
                bad++; $display("FAIL io_write got=%0d/%h/%h want=%0d/00030000/41", ow.t, ow.addr, ow.b, t + 4);
            end
        end
        total++;
        if (obs_ls.size() != 1 || obs_ls[0].t != t + 5) begin
            bad++; $display("FAIL io_ok got=%0d oks want=1 at %0d", obs_ls.size(), t + 5);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        ram[18'h100] = 8'h13; ram[18'h101] = 8'h05; ram[18'h102] = 8'h00; ram[18'h103] = 8'h00;
        ram[18'h200] = 8'h37; ram[18'h201] = 8'h01; ram[18'h202] = 8'h01; ram[18'h203] = 8'h00;
        ram[18'h2001] = 8'hAA; ram[18'h2002] = 8'hBB; ram[18'h2003] = 8'hCC; ram[18'h2004] = 8'hDD;
        test_reset();
        test_fetch();
        test_concurrent();
        test_store("store", 32'h400, 3'd4, 32'hDEAD_BEEF, 0, 0);
        test_store("rb_store", 32'h500, 3'd2, 32'h0000_1234, 1, 0);
        test_store("rdy_store", 32'h600, 3'd2, 32'h0000_5A6B, 0, 2);
        test_drop();
        test_rollback_load();
        test_rdy_fetch();
`ifdef IO_STALL_EN
        test_io_stall();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
